// File: rtl/tempo_ctl_if.sv
// Transport bundle between the button/sequencer side and tempo_ctl.
// master drives buttons and song_done; slave (tempo_ctl) drives the tempo outputs.
interface tempo_ctl_if #(
    parameter int DIV_WIDTH = 17
);
    logic                 btn_play;
    logic                 btn_faster;
    logic                 btn_slower;
    logic                 song_done;
    logic                 tempo;
    logic                 restart;
    logic                 playing;
    logic [DIV_WIDTH-1:0] div_now;

    modport master (
        output btn_play, btn_faster, btn_slower, song_done,
        input  tempo, restart, playing, div_now
    );

    modport slave (
        input  btn_play, btn_faster, btn_slower, song_done,
        output tempo, restart, playing, div_now
    );
endinterface

// File: rtl/tempo_ctl.sv
// Tempo divider and debounced play/faster/slower transport for the buzzer song player.
// Define TEMPO_CTL_LOOP_EN to restart the song on song_done instead of stopping.
module tempo_ctl #(
    parameter int DIV_WIDTH  = 17,
    parameter int BASE_DIV   = 65000,
    parameter int STEP_DIV   = 4000,
    parameter int MIN_DIV    = 33000,
    parameter int MAX_DIV    = 130000,
    parameter int DEB_CYCLES = 20800
) (
    input  logic        clk,
    input  logic        rst_n,
    tempo_ctl_if.slave  bus
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [DIV_WIDTH-1:0] BASE_V   = DIV_WIDTH'(BASE_DIV);
    localparam logic [DIV_WIDTH-1:0] STEP_V   = DIV_WIDTH'(STEP_DIV);
    localparam logic [DIV_WIDTH-1:0] MIN_V    = DIV_WIDTH'(MIN_DIV);
    localparam logic [DIV_WIDTH-1:0] MAX_V    = DIV_WIDTH'(MAX_DIV);
    localparam logic [DIV_WIDTH-1:0] LO_LIM   = DIV_WIDTH'(MIN_DIV + STEP_DIV);
    localparam logic [DIV_WIDTH-1:0] HI_LIM   = DIV_WIDTH'(MAX_DIV - STEP_DIV);

    typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_PAUSE} state_t;

    // Button index: 0 play, 1 faster, 2 slower.
    logic [2:0]    raw;
    logic [2:0]    s1_q, s1_d, s2_q, s2_d;
    logic [2:0]    deb_q, deb_d, last_q, last_d, press_q, press_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] phase_q, phase_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 tempo_q, tempo_d;
    logic                 restart_q, restart_d;
    logic                 playing_q, playing_d;

    assign raw = {bus.btn_slower, bus.btn_faster, bus.btn_play};

    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        last_d  = deb_q;
        press_d = deb_q & ~last_q;
        deb_d   = deb_q;
        for (int unsigned i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            // Count consecutive samples disagreeing with the accepted level.
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        div_d = div_q;
        if (press_q[1] && !press_q[2]) begin
            div_d = (div_q >= LO_LIM) ? div_q - STEP_V : MIN_V;
        end else if (press_q[2] && !press_q[1]) begin
            div_d = (div_q <= HI_LIM) ? div_q + STEP_V : MAX_V;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        restart_d = 1'b0;
        case (state_q)
            ST_STOP: begin
                phase_d = '0;
                if (press_q[0]) begin
                    state_d   = ST_PLAY;
                    restart_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.song_done) begin
                    phase_d = '0;
`ifdef TEMPO_CTL_LOOP_EN
                    restart_d = 1'b1;
`else
                    state_d = ST_STOP;
`endif
                end else if (press_q[0]) begin
                    state_d = ST_PAUSE;
                end else if (phase_q >= div_d - 1'b1) begin
                    // Compared against the updated period so a shrink never overruns.
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (press_q[0]) begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_STOP;
        endcase

        case (state_d)
            ST_STOP:  tempo_d = 1'b0;
            ST_PAUSE: tempo_d = tempo_q;
            default:  tempo_d = (phase_d >= (div_d >> 1));
        endcase
        playing_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            deb_q     <= '0;
            last_q    <= '0;
            press_q   <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            state_q   <= ST_STOP;
            phase_q   <= '0;
            div_q     <= BASE_V;
            tempo_q   <= 1'b0;
            restart_q <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            deb_q     <= deb_d;
            last_q    <= last_d;
            press_q   <= press_d;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q   <= state_d;
            phase_q   <= phase_d;
            div_q     <= div_d;
            tempo_q   <= tempo_d;
            restart_q <= restart_d;
            playing_q <= playing_d;
        end
    end

    assign bus.tempo   = tempo_q;
    assign bus.restart = restart_q;
    assign bus.playing = playing_q;
    assign bus.div_now = div_q;
endmodule

// File: tb/tb_tempo_ctl.sv
// Bench for tempo_ctl: directed sequences, a press table and random stimulus
// checked every cycle against a behavioural model of the transport rules.
module tb_tempo_ctl;
    localparam int DW   = 17;
    localparam int BASE = 16;
    localparam int STEP = 4;
    localparam int MIN  = 8;
    localparam int MAX  = 24;
    localparam int DEB  = 3;

    localparam int M_STOP  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tempo_ctl_if #(.DIV_WIDTH(DW)) bus ();

    tempo_ctl #(
        .DIV_WIDTH (DW),
        .BASE_DIV  (BASE),
        .STEP_DIV  (STEP),
        .MIN_DIV   (MIN),
        .MAX_DIV   (MAX),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state: raw sample history per button ([0] = latest edge),
    // accepted level history ([0] = after previous edge), transport values.
    logic       rh [3][DEB+1];
    logic       dh [3][2];
    logic [2:0] m_press;
    int         m_st, m_phase, m_div;
    logic       m_tempo, m_restart, m_playing;

    typedef struct {
        logic f;
        logic s;
        int   exp_div;
    } tvec_t;
    tvec_t tbl [11];

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j <= DEB; j++) rh[b][j] = 1'b0;
            dh[b][0] = 1'b0;
            dh[b][1] = 1'b0;
        end
        m_press   = '0;
        m_st      = M_STOP;
        m_phase   = 0;
        m_div     = BASE;
        m_tempo   = 1'b0;
        m_restart = 1'b0;
        m_playing = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] pp;
        logic       raw [3];
        logic       sd, all1, all0, nd, np;
        int         ndiv;
        pp     = m_press;
        sd     = bus.song_done;
        raw[0] = bus.btn_play;
        raw[1] = bus.btn_faster;
        raw[2] = bus.btn_slower;

        ndiv = m_div;
        if (pp[1] && !pp[2]) ndiv = (m_div - STEP < MIN) ? MIN : m_div - STEP;
        if (pp[2] && !pp[1]) ndiv = (m_div + STEP > MAX) ? MAX : m_div + STEP;

        m_restart = 1'b0;
        case (m_st)
            M_STOP: begin
                m_phase = 0;
                if (pp[0]) begin
                    m_st = M_PLAY;
                    m_restart = 1'b1;
                end
            end
            M_PLAY: begin
                if (sd) begin
                    m_phase = 0;
`ifdef TEMPO_CTL_LOOP_EN
                    m_restart = 1'b1;
`else
                    m_st = M_STOP;
`endif
                end else if (pp[0]) begin
                    m_st = M_PAUSE;
                end else begin
                    m_phase = m_phase + 1;
                    if (m_phase >= ndiv) m_phase = 0;
                end
            end
            default: begin
                if (pp[0]) m_st = M_PLAY;
            end
        endcase
        m_div = ndiv;
        if (m_st == M_STOP) m_tempo = 1'b0;
        else if (m_st == M_PLAY) m_tempo = (m_phase >= ndiv / 2);
        m_playing = (m_st == M_PLAY);

        // Accepted level flips once the DEB most recent synchronized samples all differ from it.
        for (int b = 0; b < 3; b++) begin
            np = dh[b][0] & ~dh[b][1];
            all1 = 1'b1;
            all0 = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
                if (rh[b][j]) all0 = 1'b0;
                else all1 = 1'b0;
            end
            nd = dh[b][0];
            if (all1) nd = 1'b1;
            if (all0) nd = 1'b0;
            dh[b][1] = dh[b][0];
            dh[b][0] = nd;
            for (int j = DEB; j >= 1; j--) rh[b][j] = rh[b][j-1];
            rh[b][0] = raw[b];
            m_press[b] = np;
        end
    endtask

    task automatic cmp_model();
        logic [DW+2:0] act, exp;
        act = {bus.tempo, bus.restart, bus.playing, bus.div_now};
        exp = {m_tempo, m_restart, m_playing, DW'(m_div)};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL model t=%0t: got tempo=%b restart=%b playing=%b div=%0d, expected tempo=%b restart=%b playing=%b div=%0d",
                     $time, act[DW+2], act[DW+1], act[DW], act[DW-1:0],
                     m_tempo, m_restart, m_playing, m_div);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic wait_phase(input int tgt);
        int i;
        i = 0;
        while (m_phase != tgt && i < 64) begin
            tick();
            i++;
        end
        if (m_phase != tgt) begin
            n_bad++;
            $display("FAIL wait_phase: got %0d expected %0d", m_phase, tgt);
        end
    endtask

    task automatic ticks_until_tempo(input logic v, output int n);
        n = 0;
        while (bus.tempo !== v && n < 64) begin
            tick();
            n++;
        end
    endtask

    int   r_at, n_rs, rise1, fall1, rise2, n;
    logic pt;
    int   hold_left [3];
    logic lvl [3];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 12};
        tbl[1]  = '{1'b1, 1'b0, 8};
        tbl[2]  = '{1'b1, 1'b0, 8};
        tbl[3]  = '{1'b0, 1'b1, 12};
        tbl[4]  = '{1'b0, 1'b1, 16};
        tbl[5]  = '{1'b0, 1'b1, 20};
        tbl[6]  = '{1'b0, 1'b1, 24};
        tbl[7]  = '{1'b0, 1'b1, 24};
        tbl[8]  = '{1'b1, 1'b1, 24};
        tbl[9]  = '{1'b1, 1'b0, 20};
        tbl[10] = '{1'b1, 1'b0, 16};

        bus.btn_play   = 1'b0;
        bus.btn_faster = 1'b0;
        bus.btn_slower = 1'b0;
        bus.song_done  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_tempo", bus.tempo, 0);
        chk("reset_restart", bus.restart, 0);
        chk("reset_playing", bus.playing, 0);
        chk("reset_div", bus.div_now, BASE);
        rst_n = 1'b1;

        // Bouncing play button never settles long enough.
        n_rs = 0;
        for (int t = 0; t < 30; t++) begin
            bus.btn_play = (t < 20) ? logic'((t >> 1) & 1) : 1'b0;
            tick();
            if (bus.restart) n_rs++;
        end
        chk("bounce_restart", n_rs, 0);
        chk("bounce_playing", bus.playing, 0);

        // Play press held 10 cycles from STOP.
        r_at = -1; rise1 = -1; fall1 = -1; rise2 = -1; n_rs = 0;
        pt = bus.tempo;
        for (int t = 0; t < 40; t++) begin
            bus.btn_play = (t < 10);
            tick();
            if (bus.restart) begin
                n_rs++;
                if (r_at < 0) r_at = t;
            end
            if (bus.tempo && !pt) begin
                if (rise1 < 0) rise1 = t;
                else if (rise2 < 0) rise2 = t;
            end
            if (!bus.tempo && pt && fall1 < 0) fall1 = t;
            pt = bus.tempo;
        end
        chk("play_restart_count", n_rs, 1);
        chk("play_restart_latency", r_at, DEB + 3);
        chk("play_first_rise", rise1 - r_at, 8);
        chk("play_high_len", fall1 - rise1, 8);
        chk("play_low_len", rise2 - fall1, 8);
        chk("play_playing", bus.playing, 1);

        // Pause at phase 11, then resume from the frozen phase.
        wait_phase(5);
        n_rs = 0;
        bus.btn_play = 1'b1;
        repeat (DEB + 4) tick();
        chk("pause_playing", bus.playing, 0);
        chk("pause_tempo", bus.tempo, 1);
        bus.btn_play = 1'b0;
        repeat (8) begin
            tick();
            if (bus.restart) n_rs++;
        end
        chk("pause_tempo_frozen", bus.tempo, 1);
        bus.btn_play = 1'b1;
        repeat (DEB + 4) begin
            tick();
            if (bus.restart) n_rs++;
        end
        chk("resume_playing", bus.playing, 1);
        chk("resume_no_restart", n_rs, 0);
        bus.btn_play = 1'b0;
        ticks_until_tempo(1'b0, n);
        chk("resume_phase11_fall", n, 5);

        // Faster/slower press table with clamping and simultaneous press.
        for (int i = 0; i < 11; i++) begin
            bus.btn_faster = tbl[i].f;
            bus.btn_slower = tbl[i].s;
            repeat (DEB + 4) tick();
            bus.btn_faster = 1'b0;
            bus.btn_slower = 1'b0;
            repeat (DEB + 4) tick();
            chk($sformatf("div_table_%0d", i), bus.div_now, tbl[i].exp_div);
        end

        // Shrinking the period below the current phase wraps at once.
        wait_phase(7);
        bus.btn_faster = 1'b1;
        repeat (DEB + 3) tick();
        chk("wrap_pre_tempo", bus.tempo, 1);
        tick();
        chk("wrap_div", bus.div_now, 12);
        chk("wrap_tempo", bus.tempo, 0);
        bus.btn_faster = 1'b0;
        ticks_until_tempo(1'b1, n);
        chk("wrap_low_len", n, 6);
        ticks_until_tempo(1'b0, n);
        chk("wrap_high_len", n, 6);

        // End of song.
        bus.song_done = 1'b1;
        tick();
        bus.song_done = 1'b0;
`ifdef TEMPO_CTL_LOOP_EN
        chk("done_restart", bus.restart, 1);
        chk("done_playing", bus.playing, 1);
        chk("done_tempo", bus.tempo, 0);
        tick();
        chk("done_restart_once", bus.restart, 0);
`else
        chk("done_restart", bus.restart, 0);
        chk("done_playing", bus.playing, 0);
        chk("done_tempo", bus.tempo, 0);
        bus.btn_play = 1'b1;
        repeat (DEB + 4) tick();
        chk("replay_restart", bus.restart, 1);
        chk("replay_playing", bus.playing, 1);
        bus.btn_play = 1'b0;
        repeat (DEB + 4) tick();
`endif
        bus.btn_faster = 1'b1;
        repeat (DEB + 4) tick();
        bus.btn_faster = 1'b0;
        repeat (10) tick();
        chk("pre_reset_div", bus.div_now, 8);

        // Asynchronous reset mid-song.
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_tempo", bus.tempo, 0);
        chk("midreset_restart", bus.restart, 0);
        chk("midreset_playing", bus.playing, 0);
        chk("midreset_div", bus.div_now, BASE);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random buttons and song_done against the model.
        for (int b = 0; b < 3; b++) begin
            hold_left[b] = 0;
            lvl[b] = 1'b0;
        end
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] == 0) begin
                    lvl[b] = logic'($urandom_range(0, 1));
                    hold_left[b] = $urandom_range(1, 12);
                end
                hold_left[b]--;
            end
            bus.btn_play   = lvl[0];
            bus.btn_faster = lvl[1];
            bus.btn_slower = lvl[2];
            bus.song_done  = ($urandom_range(0, 47) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
